// File: rtl/pipe_ctrl_stage.sv
// Control-bundle pipeline (ID/EX, EX/MEM, MEM/WB) for the 5-stage MIPS core.
// Resolves load-use, MULTU hold, jump and taken-branch hazards and drives PC select/stall/flush.
module pipe_ctrl_stage #(
  parameter int MULT_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [3:0] id_ex,
  input  logic [2:0] id_mem,
  input  logic [1:0] id_wb,
  input  logic       id_jump,
  input  logic       id_jr,
  input  logic       id_multu,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic [4:0] id_rd,
  input  logic       mem_zero,
  output logic [3:0] ex_ctrl,
  output logic [2:0] mem_ctrl,
  output logic [1:0] wb_ctrl,
  output logic [4:0] ex_dst,
  output logic [4:0] mem_dst,
  output logic [4:0] wb_dst,
  output logic [1:0] pc_sel,
  output logic       stall_if,
  output logic       flush_ifid
);

  // The counter is loaded with the number of hold cycles; it reaches zero in the MULTU's last EX cycle.
  localparam logic [5:0] MULT_LOAD = 6'(MULT_CYCLES - 1);

  logic [2:0] ex_mem_q;
  logic [1:0] ex_wb_q;
  logic [4:0] ex_rt_q;
  logic [4:0] ex_rd_q;
  logic       ex_multu_q;
  logic [1:0] mem_wb_q;
  logic [5:0] mult_cnt;

  logic [3:0] cap_ex;
  logic [2:0] cap_mem;
  logic [1:0] cap_wb;
  logic [4:0] cap_rt;
  logic [4:0] cap_rd;
  logic       cap_multu;

  logic branch_taken;
  logic mult_hold;
  logic load_use;

  // Decoder outputs are cleaned here so don't-care bits never travel down the pipe.
  always_comb begin
    cap_ex    = '0;
    cap_mem   = '0;
    cap_wb    = '0;
    cap_rt    = '0;
    cap_rd    = '0;
    cap_multu = 1'b0;
    if (id_valid) begin
      cap_ex    = {id_ex[3] & id_wb[1], id_ex[2:0]};
      cap_mem   = {id_mem[2:1], id_mem[0] & ~id_jump};
      cap_wb    = {id_wb[1], id_wb[0] & id_wb[1]};
      cap_rt    = id_rt;
      cap_rd    = id_rd;
      cap_multu = id_multu;
    end
  end

  assign ex_dst       = ex_ctrl[3] ? ex_rd_q : ex_rt_q;
  assign branch_taken = mem_ctrl[0] & mem_zero;
  assign mult_hold    = ex_multu_q & (mult_cnt != 6'd0);
  assign load_use     = ex_mem_q[2] & (ex_dst != 5'd0) &
                        ((ex_dst == id_rs) | (ex_dst == id_rt));

  always_comb begin
    pc_sel     = 2'b00;
    stall_if   = 1'b0;
    flush_ifid = 1'b0;
    if (!rst) begin
      if (branch_taken) begin
        pc_sel     = 2'b01;
        flush_ifid = 1'b1;
      end else if (mult_hold || load_use) begin
        stall_if = 1'b1;
      end else if (id_jump) begin
        pc_sel     = id_jr ? 2'b11 : 2'b10;
        flush_ifid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_ctrl    <= '0;
      ex_mem_q   <= '0;
      ex_wb_q    <= '0;
      ex_rt_q    <= '0;
      ex_rd_q    <= '0;
      ex_multu_q <= 1'b0;
      mult_cnt   <= '0;
    end else if (branch_taken || (!mult_hold && load_use)) begin
      ex_ctrl    <= '0;
      ex_mem_q   <= '0;
      ex_wb_q    <= '0;
      ex_rt_q    <= '0;
      ex_rd_q    <= '0;
      ex_multu_q <= 1'b0;
      mult_cnt   <= '0;
    end else if (mult_hold) begin
      mult_cnt <= mult_cnt - 6'd1;
    end else begin
      ex_ctrl    <= cap_ex;
      ex_mem_q   <= cap_mem;
      ex_wb_q    <= cap_wb;
      ex_rt_q    <= cap_rt;
      ex_rd_q    <= cap_rd;
      ex_multu_q <= cap_multu;
      mult_cnt   <= cap_multu ? MULT_LOAD : 6'd0;
    end
  end

  // EX/MEM takes a bubble while EX is held or the younger instructions are being squashed.
  always_ff @(posedge clk) begin
    if (rst || branch_taken || mult_hold) begin
      mem_ctrl <= '0;
      mem_wb_q <= '0;
      mem_dst  <= '0;
    end else begin
      mem_ctrl <= ex_mem_q;
      mem_wb_q <= ex_wb_q;
      mem_dst  <= ex_dst;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_ctrl <= '0;
      wb_dst  <= '0;
    end else begin
      wb_ctrl <= mem_wb_q;
      wb_dst  <= mem_dst;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl_stage.sv
// Scoreboard bench for pipe_ctrl_stage: an instruction-level pipeline model predicts every cycle,
// a negedge monitor compares the DUT outputs against the queued predictions.
module tb_pipe_ctrl_stage;

  localparam int MC = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_jump, id_jr, id_multu, mem_zero;
  logic [3:0] id_ex;
  logic [2:0] id_mem;
  logic [1:0] id_wb;
  logic [4:0] id_rs, id_rt, id_rd;
  logic [3:0] ex_ctrl;
  logic [2:0] mem_ctrl;
  logic [1:0] wb_ctrl, pc_sel;
  logic [4:0] ex_dst, mem_dst, wb_dst;
  logic       stall_if, flush_ifid;

  typedef struct packed {
    logic       valid;
    logic [3:0] ex;
    logic [2:0] mem;
    logic [1:0] wb;
    logic       jump, jr, multu;
    logic [4:0] rs, rt, rd;
    logic       zero;
  } prog_t;

  typedef struct packed {
    logic [3:0] ex;
    logic [2:0] mem;
    logic [1:0] wb;
    logic [4:0] dst;
    logic       multu;
    logic       zero;
  } slot_t;

  typedef struct packed {
    logic [3:0] ex;
    logic [2:0] mem;
    logic [1:0] wb;
    logic [4:0] ex_dst, mem_dst, wb_dst;
    logic [1:0] pc;
    logic       st, fl;
  } exp_t;

  localparam prog_t NOP = '0;

  exp_t  exp_q[$];
  slot_t m_ex = '0, m_mem = '0, m_wb = '0;
  int    m_left = 0;
  int    errors = 0;
  int    checks = 0;

  always #5 clk = ~clk;

  pipe_ctrl_stage #(.MULT_CYCLES(MC)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ex(id_ex), .id_mem(id_mem),
    .id_wb(id_wb), .id_jump(id_jump), .id_jr(id_jr), .id_multu(id_multu),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .mem_zero(mem_zero),
    .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl),
    .ex_dst(ex_dst), .mem_dst(mem_dst), .wb_dst(wb_dst),
    .pc_sel(pc_sel), .stall_if(stall_if), .flush_ifid(flush_ifid)
  );

  function automatic prog_t mk(input logic [3:0] ex, input logic [2:0] mem, input logic [1:0] wb,
                               input logic jump, input logic jr, input logic multu,
                               input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                               input logic zero);
    prog_t p;
    p.valid = 1'b1; p.ex = ex; p.mem = mem; p.wb = wb;
    p.jump = jump; p.jr = jr; p.multu = multu;
    p.rs = rs; p.rt = rt; p.rd = rd; p.zero = zero;
    return p;
  endfunction

  function automatic prog_t f_add(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    return mk(4'b1100, 3'b000, 2'b10, 1'b0, 1'b0, 1'b0, rs, rt, rd, 1'b0);
  endfunction
  function automatic prog_t f_lw(input logic [4:0] rs, input logic [4:0] rt);
    return mk(4'b0001, 3'b100, 2'b11, 1'b0, 1'b0, 1'b0, rs, rt, 5'd0, 1'b0);
  endfunction
  function automatic prog_t f_multu(input logic [4:0] rs, input logic [4:0] rt);
    return mk(4'b1100, 3'b000, 2'b01, 1'b0, 1'b0, 1'b1, rs, rt, 5'd7, 1'b0);
  endfunction
  function automatic prog_t f_beq(input logic [4:0] rs, input logic [4:0] rt, input logic z);
    return mk(4'b0010, 3'b001, 2'b00, 1'b0, 1'b0, 1'b0, rs, rt, 5'd0, z);
  endfunction
  function automatic prog_t f_jump(input logic jr, input logic [4:0] rs);
    return mk(4'b0000, 3'b001, 2'b00, 1'b1, jr, 1'b0, rs, 5'd0, 5'd0, 1'b1);
  endfunction

  // Random instruction mix; don't-care decoder bits are randomised on purpose.
  function automatic prog_t rand_instr();
    prog_t      p;
    logic [4:0] rs, rt, rd;
    rs = 5'($urandom_range(0, 7));
    rt = 5'($urandom_range(0, 7));
    rd = 5'($urandom_range(0, 7));
    case ($urandom_range(0, 8))
      0, 1: p = mk(4'b1100, 3'b000, 2'b10, 1'b0, 1'b0, 1'b0, rs, rt, rd, 1'($urandom));
      2, 3: p = mk(4'b0001, 3'b100, 2'b11, 1'b0, 1'b0, 1'b0, rs, rt, rd, 1'($urandom));
      4: p = mk({1'($urandom), 3'b001}, 3'b010, {1'b0, 1'($urandom)}, 1'b0, 1'b0, 1'b0, rs, rt, rd, 1'($urandom));
      5: p = mk({1'($urandom), 3'b010}, 3'b001, {1'b0, 1'($urandom)}, 1'b0, 1'b0, 1'b0, rs, rt, rd, 1'($urandom));
      6: p = mk({1'($urandom), 3'b100}, 3'b000, {1'b0, 1'($urandom)}, 1'b0, 1'b0, 1'b1, rs, rt, rd, 1'($urandom));
      7: p = mk(4'($urandom), 3'b001, {1'b0, 1'($urandom)}, 1'b1, 1'($urandom), 1'b0, rs, rt, rd, 1'($urandom));
      default: begin
        p = mk(4'($urandom), 3'($urandom), 2'($urandom), 1'b0, 1'b0, 1'($urandom), rs, rt, rd, 1'($urandom));
        p.valid = 1'b0;
      end
    endcase
    return p;
  endfunction

  // What an ID instruction becomes once it sits in the ID/EX register.
  function automatic slot_t decode(input prog_t p);
    slot_t s;
    s = '0;
    if (p.valid) begin
      s.ex  = p.ex;
      s.mem = p.mem;
      s.wb  = p.wb;
      if (p.jump) s.mem[0] = 1'b0;
      if (!p.wb[1]) begin
        s.ex[3] = 1'b0;
        s.wb[0] = 1'b0;
      end
      s.dst   = s.ex[3] ? p.rd : p.rt;
      s.multu = p.multu;
      s.zero  = p.zero;
    end
    return s;
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Drives one cycle, predicts its outputs and the model state after the edge.
  task automatic applyStimulus(input prog_t p, input bit r, input bit chk, output bit st, output bit fl);
    exp_t  e;
    slot_t n_ex, n_mem, n_wb;
    int    n_left;
    bit    taken, hold, lu;
    rst = r; id_valid = p.valid; id_ex = p.ex; id_mem = p.mem; id_wb = p.wb;
    id_jump = p.jump; id_jr = p.jr; id_multu = p.multu;
    id_rs = p.rs; id_rt = p.rt; id_rd = p.rd; mem_zero = m_mem.zero;
    taken = m_mem.mem[0] && m_mem.zero;
    hold  = m_ex.multu && (m_left > 1);
    lu    = m_ex.mem[2] && (m_ex.dst != 5'd0) && ((m_ex.dst == p.rs) || (m_ex.dst == p.rt));
    e = '0;
    e.ex = m_ex.ex; e.mem = m_mem.mem; e.wb = m_wb.wb;
    e.ex_dst = m_ex.dst; e.mem_dst = m_mem.dst; e.wb_dst = m_wb.dst;
    if (!r) begin
      if (taken) begin
        e.pc = 2'b01; e.fl = 1'b1;
      end else if (hold || lu) begin
        e.st = 1'b1;
      end else if (p.jump) begin
        e.pc = p.jr ? 2'b11 : 2'b10; e.fl = 1'b1;
      end
    end
    st = e.st;
    fl = e.fl;
    if (chk) exp_q.push_back(e);
    n_left = 0;
    if (r) begin
      n_ex = '0; n_mem = '0; n_wb = '0;
    end else begin
      n_wb  = m_mem;
      n_mem = (taken || hold) ? slot_t'('0) : m_ex;
      if (taken || (!hold && lu)) begin
        n_ex = '0;
      end else if (hold) begin
        n_ex = m_ex; n_left = m_left - 1;
      end else begin
        n_ex = decode(p); n_left = n_ex.multu ? MC : 0;
      end
    end
    @(posedge clk);
    m_ex = n_ex; m_mem = n_mem; m_wb = n_wb; m_left = n_left;
    #1;
  endtask

  // Simple fetch front end: holds ID on stall, inserts a bubble after a flush.
  task automatic run_program(input prog_t prog[$]);
    prog_t cur;
    int    idx;
    int    guard;
    bit    st, fl;
    cur = prog[0]; idx = 1; guard = 0;
    forever begin
      applyStimulus(cur, 1'b0, 1'b1, st, fl);
      guard++;
      if (fl) cur = NOP;
      else if (!st) begin
        if (idx < prog.size()) begin
          cur = prog[idx]; idx++;
        end else break;
      end
      if (guard > 2000) begin
        checks++; errors++;
        $display("[TB] FAIL program_progress: got %0d cycles expected under 2000", guard);
        break;
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("ex_ctrl",    8'(ex_ctrl),    8'(e.ex));
        checkOutput("mem_ctrl",   8'(mem_ctrl),   8'(e.mem));
        checkOutput("wb_ctrl",    8'(wb_ctrl),    8'(e.wb));
        checkOutput("ex_dst",     8'(ex_dst),     8'(e.ex_dst));
        checkOutput("mem_dst",    8'(mem_dst),    8'(e.mem_dst));
        checkOutput("wb_dst",     8'(wb_dst),     8'(e.wb_dst));
        checkOutput("pc_sel",     8'(pc_sel),     8'(e.pc));
        checkOutput("stall_if",   8'(stall_if),   8'(e.st));
        checkOutput("flush_ifid", 8'(flush_ifid), 8'(e.fl));
      end
    end
  end

  initial begin
    prog_t q[$];
    bit    st, fl;
    applyStimulus(NOP, 1'b1, 1'b0, st, fl);
    applyStimulus(NOP, 1'b1, 1'b1, st, fl);

    q.delete();
    q.push_back(f_add(5'd1, 5'd2, 5'd3)); q.push_back(f_add(5'd4, 5'd5, 5'd3));
    q.push_back(f_add(5'd6, 5'd7, 5'd3));
    q.push_back(f_lw(5'd0, 5'd8));        q.push_back(f_add(5'd8, 5'd9, 5'd3));
    q.push_back(f_multu(5'd4, 5'd5));     q.push_back(f_add(5'd1, 5'd2, 5'd6));
    q.push_back(f_multu(5'd4, 5'd5));     q.push_back(f_multu(5'd6, 5'd7));
    q.push_back(f_beq(5'd1, 5'd1, 1'b1)); q.push_back(f_multu(5'd2, 5'd3));
    q.push_back(f_add(5'd1, 5'd2, 5'd4)); q.push_back(f_add(5'd1, 5'd2, 5'd5));
    q.push_back(f_jump(1'b0, 5'd0));      q.push_back(NOP);
    q.push_back(f_jump(1'b1, 5'd31));     q.push_back(NOP);
    q.push_back(f_lw(5'd0, 5'd9));        q.push_back(f_jump(1'b0, 5'd9));
    for (int i = 0; i < 8; i++) q.push_back(NOP);
    run_program(q);

    applyStimulus(f_multu(5'd2, 5'd3), 1'b0, 1'b1, st, fl);
    applyStimulus(NOP, 1'b0, 1'b1, st, fl);
    applyStimulus(NOP, 1'b1, 1'b1, st, fl);
    for (int i = 0; i < 3; i++) applyStimulus(NOP, 1'b0, 1'b1, st, fl);

    q.delete();
    for (int i = 0; i < 150; i++) q.push_back(rand_instr());
    for (int i = 0; i < 8; i++) q.push_back(NOP);
    run_program(q);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
